// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the MEM-stage data memory controller:
//   - access size encodings driven on mem_size
//   - controller FSM state encoding
//   - clog2 helper used to size address/index fields from DEPTH
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : data_mem_pkg

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for a little-endian 32-bit data memory.
// Ports:
//   addr_lo_i  [1:0]  byte offset within the word (address[1:0])
//   size_i     [1:0]  access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   unsigned_i        1 = zero-extend byte/half loads
//   wdata_i    [31:0] store data, valid bits at the LSBs for byte/half
//   rword_i    [31:0] word currently stored at the addressed location
//   be_o       [3:0]  byte enables for the store
//   wdata_o    [31:0] store data replicated onto every candidate lane
//   rdata_o    [31:0] load data shifted to the LSBs and extended
// ---------------------------------------------------------------------------
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane data is replicated so the byte enables alone decide which lanes
    // are written; no per-lane shifting is needed on the store path.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        rdata_o = 32'd0;
        case (size_i)
            SZ_BYTE: rdata_o = unsigned_i ? {24'd0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = unsigned_i ? {16'd0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = 32'd0;
        endcase
    end

endmodule : mem_lane_align

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// MEM-stage data memory for the pipelined MIPS datapath. Byte/half/word loads
// and stores with sign/zero extension, WAIT_CYCLES extra cycles per access
// with a stall handshake, alignment/range fault flags, and a clear sweep of
// the whole array after every reset.
// Parameters:
//   DEPTH        number of 32-bit words (power of 2, >= 2)
//   WAIT_CYCLES  extra cycles per access (0..7); 0 = single-cycle access
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   address       byte address from the ALU
//   write_data    store data (LSBs for sb/sh)
//   MemWrite      store request
//   MemRead       load request
//   mem_size      00 byte, 01 half, 10 word, 11 illegal
//   mem_unsigned  zero-extend byte/half loads
//   Read_data     extended load result, 0 unless a load completes this cycle
//   mem_stall     hold the pipeline; request inputs must stay stable
//   misalign      size/alignment fault (forced 0 while clearing)
//   out_of_range  word address beyond DEPTH (forced 0 while clearing)
//   init_done     clear sweep finished
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] Read_data,
    output logic        mem_stall,
    output logic        misalign,
    output logic        out_of_range,
    output logic        init_done
);

    localparam int          AW       = clog2(DEPTH);
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam bit          HAS_WAIT = (WAIT_CYCLES > 0);
    // The IDLE cycle that accepts a request is itself the first stall cycle,
    // so BUSY only has to count the remaining WAIT_CYCLES-1.
    localparam logic [2:0]  CNT_INIT = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            init_done_q, init_done_d;

    logic [31:0]     mem_q [DEPTH];

    logic [31:0]     word_addr;
    logic [AW-1:0]   word_idx;
    logic            misalign_raw;
    logic            oor_raw;
    logic            in_clear;
    logic            req;
    logic            complete;
    logic            clr_we;
    logic            stall;
    logic            wr_commit;
    logic            rd_commit;

    logic [31:0]     rword;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic [31:0]     rdata_ext;

    // ------------------------------------------------------------------
    // Address decode and fault flags
    // ------------------------------------------------------------------
    assign word_addr = {2'b00, address[31:2]};
    assign word_idx  = address[AW+1:2];
    assign oor_raw   = (word_addr >= DEPTH_U);

    always_comb begin
        misalign_raw = 1'b0;
        case (mem_size)
            SZ_BYTE: misalign_raw = 1'b0;
            SZ_HALF: misalign_raw = address[0];
            SZ_WORD: misalign_raw = |address[1:0];
            default: misalign_raw = 1'b1;
        endcase
    end

    assign in_clear     = (state_q == ST_CLEAR);
    assign misalign     = ~in_clear & misalign_raw;
    assign out_of_range = ~in_clear & oor_raw;
    assign req          = (MemRead | MemWrite) & ~misalign_raw & ~oor_raw;

    // ------------------------------------------------------------------
    // Controller FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        stall       = 1'b0;
        complete    = 1'b0;
        clr_we      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                stall     = 1'b1;
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == CLR_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    clr_idx_d   = '0;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (HAS_WAIT) begin
                        stall   = 1'b1;
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    // Requester withdrew: abandon the access without committing.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q != 3'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                cnt_d       = 3'd0;
                clr_idx_d   = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= 3'd0;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array and lane steering
    // ------------------------------------------------------------------
    assign rword = mem_q[word_idx];

    mem_lane_align u_lane_align (
        .addr_lo_i  (address[1:0]),
        .size_i     (mem_size),
        .unsigned_i (mem_unsigned),
        .wdata_i    (write_data),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_rep),
        .rdata_o    (rdata_ext)
    );

    // A simultaneous read+write request is treated as a store.
    assign wr_commit = complete & MemWrite;
    assign rd_commit = complete & MemRead & ~MemWrite;

    // Gating on rst_n drops any write that coincides with reset, including
    // the completion of an in-flight BUSY store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                    end
                end
            end
        end
    end

    assign Read_data = rd_commit ? rdata_ext : 32'd0;
    assign mem_stall = stall;
    assign init_done = init_done_q;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl with DEPTH=16, WAIT_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] Read_data;
    logic        mem_stall;
    logic        misalign;
    logic        out_of_range;
    logic        init_done;

    int n_chk  = 0;
    int n_pass = 0;
    int rd_bad = 0;

    data_mem_ctrl #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .write_data   (write_data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .Read_data    (Read_data),
        .mem_stall    (mem_stall),
        .misalign     (misalign),
        .out_of_range (out_of_range),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive one request at posedge+1 and hold it until a non-stall cycle is
    // seen; returns the data/flags of that cycle. Ends at posedge+1 with the
    // strobes released.
    task automatic access(input logic wr, input logic rd, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdat, output int stalls,
                          output logic mis, output logic oor);
        bit done;
        MemWrite     = wr;
        MemRead      = rd;
        mem_size     = sz;
        mem_unsigned = uns;
        address      = addr;
        write_data   = wd;
        stalls = 0;
        rdat   = 32'd0;
        mis    = 1'b0;
        oor    = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) begin
                stalls++;
                if (Read_data != 32'd0) rd_bad++;
                @(posedge clk);
                #1;
            end else begin
                rdat = Read_data;
                mis  = misalign;
                oor  = out_of_range;
                done = 1'b1;
            end
        end
        if (!done) chk("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    // Hold reset two more cycles, release it, and measure the clear sweep.
    // A half access at an odd address is presented throughout to check that
    // misalign stays masked while clearing. Ends at posedge+1 in IDLE.
    task automatic do_reset(output int cycles, output int stall_lo, output int mis_hi);
        rst_n    = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        address  = 32'h5;
        mem_size = H;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cycles   = 0;
        stall_lo = 0;
        mis_hi   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (init_done) break;
            cycles++;
            if (!mem_stall) stall_lo++;
            if (misalign)   mis_hi++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          st;
        logic        mis;
        logic        oor;
        int          cyc;
        int          slo;
        int          mhi;

        rst_n        = 1'b0;
        address      = 32'd0;
        write_data   = 32'd0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        mem_size     = W;
        mem_unsigned = 1'b0;

        // Reset state and clear sweep
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd1);
        do_reset(cyc, slo, mhi);
        chk("clr_cycles", 32'(cyc), 32'd16);
        chk("clr_stall_low", 32'(slo), 32'd0);
        chk("clr_misalign_masked", 32'(mhi), 32'd0);
        chk("init_done_high", 32'(init_done), 32'd1);
        access(0, 1, W, 0, 32'h24, 0, rd, st, mis, oor);
        chk("lw_after_clear", rd, 32'd0);
        chk("lw_stall_cycles", 32'(st), 32'd3);

        // Word and byte lanes
        access(1, 0, W, 0, 32'h8, 32'h8899AABB, rd, st, mis, oor);
        chk("sw_stall_cycles", 32'(st), 32'd3);
        chk("sw_rdata_zero", rd, 32'd0);
        access(1, 0, B, 0, 32'h9, 32'h0000007F, rd, st, mis, oor);
        access(0, 1, W, 0, 32'h8, 0, rd, st, mis, oor);
        chk("lw_0x8", rd, 32'h88997FBB);
        access(0, 1, B, 0, 32'hB, 0, rd, st, mis, oor);
        chk("lb_0xB", rd, 32'hFFFFFF88);
        access(0, 1, B, 1, 32'hB, 0, rd, st, mis, oor);
        chk("lbu_0xB", rd, 32'h00000088);
        access(0, 1, B, 0, 32'h9, 0, rd, st, mis, oor);
        chk("lb_0x9_pos", rd, 32'h0000007F);
        access(0, 1, H, 0, 32'h8, 0, rd, st, mis, oor);
        chk("lh_0x8", rd, 32'h00007FBB);

        // Halfwords and misalignment
        access(1, 0, H, 0, 32'h6, 32'h1234F00D, rd, st, mis, oor);
        access(0, 1, H, 0, 32'h6, 0, rd, st, mis, oor);
        chk("lh_0x6", rd, 32'hFFFFF00D);
        access(0, 1, H, 1, 32'h6, 0, rd, st, mis, oor);
        chk("lhu_0x6", rd, 32'h0000F00D);
        access(0, 1, W, 0, 32'h4, 0, rd, st, mis, oor);
        chk("lw_0x4_lanes", rd, 32'hF00D0000);
        access(0, 1, H, 0, 32'h5, 0, rd, st, mis, oor);
        chk("lh_0x5_misalign", 32'(mis), 32'd1);
        chk("lh_0x5_rdata", rd, 32'd0);
        chk("lh_0x5_nostall", 32'(st), 32'd0);
        access(0, 1, X, 0, 32'h8, 0, rd, st, mis, oor);
        chk("size11_misalign", 32'(mis), 32'd1);
        chk("size11_rdata", rd, 32'd0);

        // Store withdrawn before its final cycle does not commit
        access(1, 0, W, 0, 32'hC, 32'h11223344, rd, st, mis, oor);
        MemWrite   = 1'b1;
        address    = 32'hC;
        mem_size   = W;
        write_data = 32'h55667788;
        st = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_stall) st++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sw_4th_cycle_nostall", 32'(mem_stall), 32'd0);
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_drop_stalls", 32'(st), 32'd3);
        access(0, 1, W, 0, 32'hC, 0, rd, st, mis, oor);
        chk("sw_dropped_no_commit", rd, 32'h11223344);

        // Reset during a BUSY store
        MemWrite   = 1'b1;
        address    = 32'h0;
        mem_size   = W;
        write_data = 32'h00001234;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_before_reset", 32'(mem_stall), 32'd1);
        do_reset(cyc, slo, mhi);
        chk("clr2_cycles", 32'(cyc), 32'd16);
        access(0, 1, W, 0, 32'h0, 0, rd, st, mis, oor);
        chk("lw_0x0_after_abort", rd, 32'd0);
        access(0, 1, W, 0, 32'hC, 0, rd, st, mis, oor);
        chk("lw_0xC_cleared", rd, 32'd0);

        // Range limits and read+write together
        access(1, 0, W, 0, 32'h400, 32'hDEADBEEF, rd, st, mis, oor);
        chk("oor_0x400", 32'(oor), 32'd1);
        chk("oor_nostall", 32'(st), 32'd0);
        access(1, 0, W, 0, 32'h40, 32'hDEADBEEF, rd, st, mis, oor);
        chk("oor_0x40", 32'(oor), 32'd1);
        access(0, 1, W, 0, 32'h0, 0, rd, st, mis, oor);
        chk("oor_mem_unchanged", rd, 32'd0);
        access(1, 0, W, 0, 32'h3C, 32'hA5A5A5A5, rd, st, mis, oor);
        chk("inrange_0x3C", 32'(oor), 32'd0);
        access(0, 1, W, 0, 32'h3C, 0, rd, st, mis, oor);
        chk("lw_0x3C", rd, 32'hA5A5A5A5);
        access(1, 1, W, 0, 32'h4, 32'hCAFEF00D, rd, st, mis, oor);
        chk("rw_rdata_zero", rd, 32'd0);
        access(0, 1, W, 0, 32'h4, 0, rd, st, mis, oor);
        chk("rw_write_applied", rd, 32'hCAFEF00D);

        chk("rdata_zero_in_stall", 32'(rd_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_data_mem_ctrl
